i2c_txn_arbiter: RTL
====================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one I2C byte engine (start/stop/byte shift + ACK) among N_REQ requesters.
//  Arbitrates requests round-robin, expands each into an engine command sequence, returns read data and completion status.
//  Sits between client logic (sensor pollers, config loaders) and the bit-level I2C engine driving sda/scl.
// PARAMETERS
//  N_REQ    2     number of requesters (1..8)
//  LEN_W    4     width of read length field; max read burst 2^LEN_W-1 bytes
//  TMO_CYC  4096  cycles allowed from cmd accept to rsp_valid before abort
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high reset
//  req_valid    in   N_REQ      per-requester request pending
//  req_ready    out  N_REQ      one-hot; request accepted when valid&ready
//  req_rw       in   N_REQ      1=read, 0=write
//  req_dev      in   7*N_REQ    7-bit device address, slice i = requester i
//  req_reg      in   8*N_REQ    register/sub-address byte
//  req_wdata    in   8*N_REQ    write data byte (write txns, 1 byte)
//  req_len      in   LEN_W*N_REQ read byte count (read txns)
//  cmd_valid    out  1          engine command valid, held until cmd_ready
//  cmd_ready    in   1          engine accepts command
//  cmd_op       out  3          0 START,1 WRITE,2 READ_ACK,3 READ_NACK,4 STOP,5 RESTART
//  cmd_wdata    out  8          byte for WRITE
//  rsp_valid    in   1          1-cycle pulse: command finished
//  rsp_ack      in   1          WRITE only: 1=slave ACKed
//  rsp_rdata    in   8          READ_* data byte
//  rd_valid     out  1          1-cycle read byte strobe
//  rd_data      out  8          read byte
//  rd_last      out  1          final byte of burst
//  done_valid   out  1          1-cycle completion pulse
//  done_id      out  3          requester index of completed txn (also valid with rd_valid)
//  done_err     out  1          1 = NACK, timeout or len==0 read
//  busy         out  1          transaction in progress
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer = 0; timeout counter 0. Reset mid-txn abandons it, no STOP, no done.
//  IDLE: scan req_valid from (ptr) upward modulo N_REQ; first set bit i wins. Same cycle: req_ready[i]=1,
//   latch rw/dev/reg/wdata/len slice i, id=i, ptr<=i+1 (wrap N_REQ->0), busy<=1 next cycle. No valid -> stay.
//  Requester 0 alone: granted every time; no starvation: each loser wins within N_REQ grants.
//  Command step = ISSUE (cmd_valid=1 until cmd_ready) then WAIT (rsp_valid). One command outstanding; cmd_op/wdata stable while valid.
//  Write seq: START, WRITE{dev,0}, WRITE reg, WRITE wdata, STOP, DONE.
//  Read seq:  START, WRITE{dev,0}, WRITE reg, RESTART, WRITE{dev,1}, READ x len, STOP, DONE.
//   Bytes 1..len-1 use READ_ACK, last uses READ_NACK. Each read rsp -> rd_valid=1 next cycle, rd_last on last.
//  rsp_ack=0 on any WRITE: skip remaining bytes, issue STOP, done_err=1.
//  Read with len==0: accepted, no engine commands, done_valid+done_err=1 one cycle after accept.
//  Timeout: counter cleared on cmd accept, counts in WAIT; reaching TMO_CYC -> go IDLE directly (no STOP),
//   done_valid=1, done_err=1; late rsp_valid while IDLE ignored.
//  DONE: done_valid=1 for 1 cycle with done_id; busy=0 same cycle; next arbitration the cycle after.
//  rsp_valid outside WAIT ignored. Requester may drop req_valid before grant; no grant issued then.
// TESTING
//  Write req0 dev=0x50 reg=0x10 wdata=0xAA, all ACK -> ops 0,1(0xA0),1(0x10),1(0xAA),4; done id0 err0.
//  Read req1 dev=0x50 reg=0x00 len=3, rdata 0x11,0x22,0x33 -> ops 0,1(0xA0),1,5,1(0xA1),2,2,3,4; rd 11,22,33 last on 33.
//  Both req_valid held, 4 txns -> grants 0,1,0,1; req_ready one-hot single-cycle each.
//  rsp_ack=0 on dev byte -> next op STOP, done_err=1, no REG/data bytes issued.
//  Withhold rsp_valid TMO_CYC cycles -> done_err=1, back to IDLE; read len=0 -> done_err=1, no cmd_valid.
//  Assert reset mid read burst -> all outputs 0 next cycle, ptr=0, new request then starts at START.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C byte engine among N_REQ clients.
// Each grant is expanded into START/WRITE/RESTART/READ/STOP engine commands.
module i2c_txn_arbiter #(
   parameter int N_REQ   = 2,
   parameter int LEN_W   = 4,
   parameter int TMO_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ-1:0]       req_rw,
   input  logic [7*N_REQ-1:0]     req_dev,
   input  logic [8*N_REQ-1:0]     req_reg,
   input  logic [8*N_REQ-1:0]     req_wdata,
   input  logic [LEN_W*N_REQ-1:0] req_len,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [2:0]             cmd_op,
   output logic [7:0]             cmd_wdata,
   input  logic                   rsp_valid,
   input  logic                   rsp_ack,
   input  logic [7:0]             rsp_rdata,
   output logic                   rd_valid,
   output logic [7:0]             rd_data,
   output logic                   rd_last,
   output logic                   done_valid,
   output logic [2:0]             done_id,
   output logic                   done_err,
   output logic                   busy
);

   localparam int TW = $clog2(TMO_CYC + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] P_START = 3'd0;
   localparam logic [2:0] P_DEV   = 3'd1;
   localparam logic [2:0] P_REG   = 3'd2;
   localparam logic [2:0] P_DATA  = 3'd3;
   localparam logic [2:0] P_RST   = 3'd4;
   localparam logic [2:0] P_DEVR  = 3'd5;
   localparam logic [2:0] P_READ  = 3'd6;
   localparam logic [2:0] P_STOP  = 3'd7;

   localparam logic [2:0] OP_START = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_RACK  = 3'd2;
   localparam logic [2:0] OP_RNACK = 3'd3;
   localparam logic [2:0] OP_STOP  = 3'd4;
   localparam logic [2:0] OP_RST   = 3'd5;

   logic [1:0]       state;
   logic [2:0]       phase;
   logic [2:0]       ptr;
   logic [2:0]       id_q;
   logic             rw_q;
   logic [6:0]       dev_q;
   logic [7:0]       reg_q;
   logic [7:0]       wdata_q;
   logic [LEN_W-1:0] cnt;
   logic             err;
   logic [TW-1:0]    tmo;

   logic             gnt_hit;
   logic [2:0]       gnt_idx;
   logic             g_rw;
   logic [6:0]       g_dev;
   logic [7:0]       g_reg;
   logic [7:0]       g_wdata;
   logic [LEN_W-1:0] g_len;
   logic [2:0]       op;
   logic [7:0]       wd;
   logic             is_write;
   int               j;

   // Scan from ptr upward, wrapping, first pending requester wins
   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = 3'd0;
      j = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!gnt_hit && req_valid[j]) begin
            gnt_hit = 1'b1;
            gnt_idx = 3'(j);
         end
      end
   end

   always_comb begin
      g_rw    = req_rw[gnt_idx];
      g_dev   = req_dev[int'(gnt_idx)*7 +: 7];
      g_reg   = req_reg[int'(gnt_idx)*8 +: 8];
      g_wdata = req_wdata[int'(gnt_idx)*8 +: 8];
      g_len   = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
   end

   assign req_ready = (!reset && state == S_IDLE && gnt_hit)
                    ? (N_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      op = OP_STOP;
      wd = 8'h00;
      is_write = 1'b0;
      unique case (phase)
         P_START: op = OP_START;
         P_DEV: begin
            op = OP_WRITE;
            wd = {dev_q, 1'b0};
            is_write = 1'b1;
         end
         P_REG: begin
            op = OP_WRITE;
            wd = reg_q;
            is_write = 1'b1;
         end
         P_DATA: begin
            op = OP_WRITE;
            wd = wdata_q;
            is_write = 1'b1;
         end
         P_RST: op = OP_RST;
         P_DEVR: begin
            op = OP_WRITE;
            wd = {dev_q, 1'b1};
            is_write = 1'b1;
         end
         P_READ: op = (cnt == LEN_W'(1)) ? OP_RNACK : OP_RACK;
         P_STOP: op = OP_STOP;
      endcase
   end

   assign cmd_valid = (state == S_ISSUE);
   assign cmd_op    = cmd_valid ? op : 3'd0;
   assign cmd_wdata = cmd_valid ? wd : 8'h00;
   assign done_id   = id_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         phase      <= P_START;
         ptr        <= 3'd0;
         id_q       <= 3'd0;
         rw_q       <= 1'b0;
         dev_q      <= 7'd0;
         reg_q      <= 8'd0;
         wdata_q    <= 8'd0;
         cnt        <= '0;
         err        <= 1'b0;
         tmo        <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= 8'd0;
         rd_last    <= 1'b0;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (gnt_hit) begin
                  id_q    <= gnt_idx;
                  rw_q    <= g_rw;
                  dev_q   <= g_dev;
                  reg_q   <= g_reg;
                  wdata_q <= g_wdata;
                  cnt     <= g_len;
                  err     <= 1'b0;
                  phase   <= P_START;
                  ptr     <= (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
                  if (g_rw && g_len == '0) begin
                     state      <= S_DONE;
                     done_valid <= 1'b1;
                     done_err   <= 1'b1;
                  end else begin
                     state <= S_ISSUE;
                     busy  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  state <= S_WAIT;
                  tmo   <= '0;
               end
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  state <= S_ISSUE;
                  if (is_write && !rsp_ack) begin
                     err   <= 1'b1;
                     phase <= P_STOP;
                  end else begin
                     unique case (phase)
                        P_START: phase <= P_DEV;
                        P_DEV:   phase <= P_REG;
                        P_REG:   phase <= rw_q ? P_RST : P_DATA;
                        P_DATA:  phase <= P_STOP;
                        P_RST:   phase <= P_DEVR;
                        P_DEVR:  phase <= P_READ;
                        P_READ: begin
                           rd_valid <= 1'b1;
                           rd_data  <= rsp_rdata;
                           rd_last  <= (cnt == LEN_W'(1));
                           cnt      <= cnt - LEN_W'(1);
                           if (cnt == LEN_W'(1)) phase <= P_STOP;
                        end
                        P_STOP: begin
                           state      <= S_DONE;
                           done_valid <= 1'b1;
                           done_err   <= err;
                           busy       <= 1'b0;
                        end
                     endcase
                  end
               end else if (tmo == TW'(TMO_CYC - 1)) begin
                  // Abort without STOP; the engine is presumed wedged
                  state      <= S_IDLE;
                  done_valid <= 1'b1;
                  done_err   <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            S_DONE: state <= S_IDLE;
         endcase
      end
   end

endmodule
